enemy_fire_ctrl: RTL and testbench
==================================

ENEMY_FIRE_CTRL -- requirements
Module: enemy_fire_ctrl

Upstream shot scheduler for the enemy projectile mover. It drives the mover's fire, timer and randomValue inputs and watches its shooting output.

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 60: frames between end of one shot and arming of next; legal 1..255.
REQ-002 Parameter ARM_TIMEOUT, default 4: frames fire may stay asserted without a launch being seen; legal 1..15.
REQ-003 Parameter MAX_SHOTS, default 8: shots per round; legal 1..15.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; nonzero.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 resetN  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007 startOfFrame  input  1  one-clk pulse per video frame.
REQ-008 preGame  input  1  high = game not running; forces idle.
REQ-009 shooting  input  1  mover's in-flight flag.
REQ-010 fire  output  1  shot approval to mover.
REQ-011 timer  output  1  shot timing strobe to mover; always equal to fire.
REQ-012 randomValue  output  5 signed  launch randomiser, range 0..15; bit 4 always 0.
REQ-013 shotsFired  output  4  launches counted this round.
REQ-014 ammoEmpty  output  1  high when the round's shots are exhausted.

Function
REQ-015 FSM states: IDLE_ST, COOLDOWN_ST, ARMED_ST, FLIGHT_ST, EMPTY_ST.
REQ-016 All outputs are registered, so every output change lags the causing state transition by zero cycles (outputs and state update on the same edge).
REQ-017 preGame=1 in any state: next state IDLE_ST; fire/timer 0; shotsFired 0; ammoEmpty 0.
  - preGame has priority over every other transition.
REQ-018 IDLE_ST with preGame=0: go to COOLDOWN_ST; load frame counter with COOLDOWN_FRAMES; clear shotsFired.
REQ-019 COOLDOWN_ST, startOfFrame=1:
  - counter<=1: go to ARMED_ST, latch randomValue={1'b0,lfsr[3:0]}, load arm counter with ARM_TIMEOUT.
  - otherwise: decrement counter.
  - net effect: ARMED_ST is entered on the clock of the COOLDOWN_FRAMES-th startOfFrame pulse after entry.
REQ-020 ARMED_ST: fire=timer=1.
  - shooting=1: go to FLIGHT_ST, shotsFired+1, fire/timer 0.
  - else on startOfFrame: decrement arm counter; on reaching 0, go to COOLDOWN_ST reloaded with COOLDOWN_FRAMES; shotsFired unchanged.
REQ-021 Same clock has shooting=1 and arm timeout: launch (FLIGHT_ST) wins.
REQ-022 FLIGHT_ST: fire=timer=0; randomValue held.
  - shooting=0 with shotsFired==MAX_SHOTS: go to EMPTY_ST.
  - shooting=0 otherwise: go to COOLDOWN_ST reloaded.
REQ-023 EMPTY_ST: ammoEmpty=1, fire=timer=0; leaves only via preGame or reset.
REQ-024 randomValue changes only on entry to ARMED_ST; held stable through ARMED_ST and FLIGHT_ST.
REQ-025 LFSR is 16-bit Fibonacci, advancing every clk:
  - next = {fb, lfsr[15:1]}, fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5].
  - if lfsr==0, reload LFSR_SEED.
REQ-026 shotsFired saturates at MAX_SHOTS; it never wraps.
REQ-027 The frame counter is 8 bits and the arm counter is 4 bits, both unsigned; neither underflows.

Reset
REQ-028 resetN=0 at a rising clk, in any state including mid-flight or mid-cooldown, sets on the next edge:
  - state IDLE_ST; lfsr=LFSR_SEED.
  - fire=0, timer=0, randomValue=0, shotsFired=0, ammoEmpty=0.
REQ-029 While resetN=0, all inputs are ignored.

Verification (COOLDOWN_FRAMES=3, ARM_TIMEOUT=2, MAX_SHOTS=2 unless noted)
REQ-030 Reset release, preGame=0, shooting=0, frame pulse every 10 clks -> fire=timer=1 exactly on the clk of the 3rd startOfFrame after leaving IDLE_ST.
REQ-031 Armed, shooting raised for 1 clk -> fire=0 next edge and shotsFired=1; shooting low -> fire=1 again after 3 more frames.
REQ-032 Armed, shooting never raised -> fire drops on the 2nd startOfFrame; shotsFired stays 0; fire re-asserts 3 frames later.
REQ-033 Two full launch/land cycles -> shotsFired=2, ammoEmpty=1, fire stays 0; a preGame pulse clears both and restarts the cooldown.
REQ-034 shooting rise coincident with the arm-timeout startOfFrame -> FLIGHT_ST taken and shotsFired increments.
REQ-035 LFSR_SEED=16'hACE1 -> randomValue at each arming equals a bit-exact LFSR model's [3:0] at that clk, and stays in 0..15; resetN=0 mid-FLIGHT_ST -> all outputs 0 next edge.

Source files
------------

// File: rtl/enemy_fire_ctrl.sv
// Shot scheduler for the enemy projectile mover: paces fire approvals by frame cooldowns,
// times out unused approvals, and counts launches per round until ammunition runs out.
module enemy_fire_ctrl #(
   parameter int unsigned COOLDOWN_FRAMES = 60,
   parameter int unsigned ARM_TIMEOUT     = 4,
   parameter int unsigned MAX_SHOTS       = 8,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              startOfFrame,
   input  logic              preGame,
   input  logic              shooting,
   output logic              fire,
   output logic              timer,
   output logic signed [4:0] randomValue,
   output logic [3:0]        shotsFired,
   output logic              ammoEmpty
);

   typedef enum logic [2:0] {
      IDLE_ST,
      COOLDOWN_ST,
      ARMED_ST,
      FLIGHT_ST,
      EMPTY_ST
   } state_e;

   localparam logic [7:0] CoolFrames = 8'(COOLDOWN_FRAMES);
   localparam logic [3:0] ArmFrames  = 4'(ARM_TIMEOUT);
   localparam logic [3:0] MaxShots   = 4'(MAX_SHOTS);

   state_e      state_q;
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic        lfsr_fb;
   logic [7:0]  frame_cnt_q;
   logic [3:0]  arm_cnt_q;

   // An all-zero LFSR would lock up, so it is reseeded instead of shifted.
   always_comb begin
      lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      lfsr_d  = (lfsr_q == 16'h0000) ? LFSR_SEED : {lfsr_fb, lfsr_q[15:1]};
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q     <= IDLE_ST;
         lfsr_q      <= LFSR_SEED;
         frame_cnt_q <= 8'd0;
         arm_cnt_q   <= 4'd0;
         fire        <= 1'b0;
         timer       <= 1'b0;
         randomValue <= 5'sd0;
         shotsFired  <= 4'd0;
         ammoEmpty   <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         if (preGame) begin
            state_q    <= IDLE_ST;
            fire       <= 1'b0;
            timer      <= 1'b0;
            shotsFired <= 4'd0;
            ammoEmpty  <= 1'b0;
         end else begin
            case (state_q)
               IDLE_ST: begin
                  state_q     <= COOLDOWN_ST;
                  frame_cnt_q <= CoolFrames;
                  shotsFired  <= 4'd0;
                  fire        <= 1'b0;
                  timer       <= 1'b0;
               end
               COOLDOWN_ST: begin
                  if (startOfFrame) begin
                     if (frame_cnt_q <= 8'd1) begin
                        state_q     <= ARMED_ST;
                        randomValue <= {1'b0, lfsr_q[3:0]};
                        arm_cnt_q   <= ArmFrames;
                        fire        <= 1'b1;
                        timer       <= 1'b1;
                     end else begin
                        frame_cnt_q <= frame_cnt_q - 8'd1;
                     end
                  end
               end
               ARMED_ST: begin
                  // A launch seen on the timeout frame still counts as a launch.
                  if (shooting) begin
                     state_q <= FLIGHT_ST;
                     fire    <= 1'b0;
                     timer   <= 1'b0;
                     if (shotsFired < MaxShots) shotsFired <= shotsFired + 4'd1;
                  end else if (startOfFrame) begin
                     if (arm_cnt_q <= 4'd1) begin
                        state_q     <= COOLDOWN_ST;
                        frame_cnt_q <= CoolFrames;
                        arm_cnt_q   <= 4'd0;
                        fire        <= 1'b0;
                        timer       <= 1'b0;
                     end else begin
                        arm_cnt_q <= arm_cnt_q - 4'd1;
                     end
                  end
               end
               FLIGHT_ST: begin
                  if (!shooting) begin
                     if (shotsFired == MaxShots) begin
                        state_q   <= EMPTY_ST;
                        ammoEmpty <= 1'b1;
                     end else begin
                        state_q     <= COOLDOWN_ST;
                        frame_cnt_q <= CoolFrames;
                     end
                  end
               end
               EMPTY_ST: begin
                  ammoEmpty <= 1'b1;
                  fire      <= 1'b0;
                  timer     <= 1'b0;
               end
               default: begin
                  state_q <= IDLE_ST;
                  fire    <= 1'b0;
                  timer   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_enemy_fire_ctrl.sv
// Bench for enemy_fire_ctrl: directed scenarios plus random traffic, every cycle compared
// against a frame-level behavioural model of the shot scheduler.
module tb_enemy_fire_ctrl;

   localparam int CF = 3;
   localparam int AT = 2;
   localparam int MS = 2;
   localparam logic [15:0] SEED = 16'hACE1;

   logic              clk;
   logic              resetN;
   logic              startOfFrame;
   logic              preGame;
   logic              shooting;
   logic              fire;
   logic              timer;
   logic signed [4:0] randomValue;
   logic [3:0]        shotsFired;
   logic              ammoEmpty;

   int tests;
   int fails;
   int gcyc;

   enemy_fire_ctrl #(
      .COOLDOWN_FRAMES(CF),
      .ARM_TIMEOUT    (AT),
      .MAX_SHOTS      (MS),
      .LFSR_SEED      (SEED)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .preGame     (preGame),
      .shooting    (shooting),
      .fire        (fire),
      .timer       (timer),
      .randomValue (randomValue),
      .shotsFired  (shotsFired),
      .ammoEmpty   (ammoEmpty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase name, frames still to wait, frames of arming left, shots, latched random.
   typedef enum int {MIdle, MWait, MReady, MAir, MOut} mphase_e;
   mphase_e     m_phase;
   int          m_wait;
   int          m_arm;
   int          m_shots;
   int          m_rv;
   bit          m_fire;
   bit          m_empty;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic b;
      if (v == 16'h0000) return SEED;
      b = v[0] ^ v[2] ^ v[3] ^ v[5];
      return {b, v[15:1]};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, gcyc);
      end
   endtask

   task automatic model_step(input bit rn, input bit pg, input bit sof, input bit sh);
      logic [15:0] cur;
      if (!rn) begin
         m_phase = MIdle; m_lfsr = SEED; m_fire = 0; m_rv = 0; m_shots = 0;
         m_empty = 0; m_wait = 0; m_arm = 0;
         return;
      end
      cur    = m_lfsr;
      m_lfsr = lfsr_next(cur);
      if (pg) begin
         m_phase = MIdle; m_fire = 0; m_shots = 0; m_empty = 0;
         return;
      end
      case (m_phase)
         MIdle: begin m_phase = MWait; m_wait = CF; m_shots = 0; m_fire = 0; end
         MWait: if (sof) begin
            m_wait--;
            if (m_wait == 0) begin
               m_phase = MReady; m_rv = int'(cur[3:0]); m_arm = AT; m_fire = 1;
            end
         end
         MReady: begin
            if (sh) begin
               m_phase = MAir; m_fire = 0;
               m_shots = (m_shots + 1 > MS) ? MS : m_shots + 1;
            end else if (sof) begin
               m_arm--;
               if (m_arm == 0) begin m_phase = MWait; m_wait = CF; m_fire = 0; end
            end
         end
         MAir: if (!sh) begin
            if (m_shots == MS) begin m_phase = MOut; m_empty = 1; end
            else begin m_phase = MWait; m_wait = CF; end
         end
         default: begin m_fire = 0; m_empty = 1; end
      endcase
   endtask

   // One clock: drive on negedge, advance the model, compare #1 after the rising edge.
   task automatic tick(input bit rn, input bit pg, input bit sof, input bit sh);
      @(negedge clk);
      resetN = rn; preGame = pg; startOfFrame = sof; shooting = sh;
      model_step(rn, pg, sof, sh);
      @(posedge clk);
      #1;
      gcyc++;
      check("fire", int'(fire), int'(m_fire));
      check("timer", int'(timer), int'(m_fire));
      check("randomValue", int'(randomValue), m_rv);
      check("shotsFired", int'(shotsFired), m_shots);
      check("ammoEmpty", int'(ammoEmpty), int'(m_empty));
   endtask

   // Frame pulses every 10 clocks until fire reaches lvl; reports pulses seen.
   task automatic run_until(input bit lvl, output int pulses, output bit last_sof);
      bit sof;
      pulses   = 0;
      last_sof = 0;
      for (int i = 0; i < 300; i++) begin
         sof = ((gcyc % 10) == 9);
         tick(1, 0, sof, 0);
         if (sof) pulses++;
         last_sof = sof;
         if (fire == lvl) return;
      end
      check("run_until_timeout", int'(fire), int'(lvl));
   endtask

   int p;
   bit ls;

   initial begin
      tests = 0; fails = 0; gcyc = 0;
      resetN = 0; preGame = 0; startOfFrame = 0; shooting = 0;
      m_phase = MIdle; m_lfsr = SEED; m_fire = 0; m_rv = 0; m_shots = 0;
      m_empty = 0; m_wait = 0; m_arm = 0;

      tick(0, 0, 1, 1);
      tick(0, 1, 1, 1);
      check("rst_fire", int'(fire), 0);
      check("rst_rv", int'(randomValue), 0);
      check("rst_shots", int'(shotsFired), 0);
      check("rst_empty", int'(ammoEmpty), 0);
      check("model_lfsr_step", int'(lfsr_next(m_lfsr)), 32'h5670);

      // Arming on the third frame pulse after leaving idle.
      tick(1, 0, 0, 0);
      run_until(1, p, ls);
      check("arm_pulses", p, 3);
      check("arm_on_pulse", int'(ls), 1);
      check("timer_eq_fire", int'(timer), 1);

      // Launch, land, re-arm after three frames.
      tick(1, 0, 0, 1);
      check("launch_fire", int'(fire), 0);
      check("launch_shots", int'(shotsFired), 1);
      tick(1, 0, 0, 0);
      run_until(1, p, ls);
      check("rearm_pulses", p, 3);

      // Unused approval times out on the second pulse, then re-arms.
      run_until(0, p, ls);
      check("timeout_pulses", p, 2);
      check("timeout_shots", int'(shotsFired), 1);
      run_until(1, p, ls);
      check("post_timeout_pulses", p, 3);

      // Second launch empties the round.
      tick(1, 0, 0, 1);
      check("launch2_shots", int'(shotsFired), 2);
      tick(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) tick(1, 0, ((gcyc % 10) == 9), 0);
      check("empty_flag", int'(ammoEmpty), 1);
      check("empty_fire", int'(fire), 0);

      // preGame clears the round and restarts cooldown.
      tick(1, 1, 0, 0);
      check("pg_shots", int'(shotsFired), 0);
      check("pg_empty", int'(ammoEmpty), 0);
      tick(1, 0, 0, 0);
      run_until(1, p, ls);
      check("pg_rearm_pulses", p, 3);

      // Launch coincident with the timeout pulse wins.
      tick(1, 0, 1, 0);
      check("armed_hold", int'(fire), 1);
      tick(1, 0, 1, 1);
      check("coincide_fire", int'(fire), 0);
      check("coincide_shots", int'(shotsFired), 1);
      tick(1, 0, 0, 0);

      // Reset in flight clears every output.
      run_until(1, p, ls);
      tick(1, 0, 0, 1);
      tick(0, 0, 0, 1);
      check("midflight_rst_fire", int'(fire), 0);
      check("midflight_rst_rv", int'(randomValue), 0);
      check("midflight_rst_shots", int'(shotsFired), 0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
         check("rv_bit4", int'(randomValue[4]), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
